// File: rtl/udma_i2c_reg_if_mc_pkg.sv
// udma_i2c_reg_pkg: shared constants for the multi-core uDMA I2C register file.
// Holds the per-channel word offsets, the global-block offsets (relative to NB_CH*8),
// the CFG register bit positions, the NACK counter width and a CFG read-data packer.
package udma_i2c_reg_pkg;

    // Word offset of a register inside one core's 8-word channel window.
    typedef enum logic [2:0] {
        CH_RX_SADDR = 3'd0,
        CH_RX_SIZE  = 3'd1,
        CH_RX_CFG   = 3'd2,
        CH_RSVD3    = 3'd3,
        CH_TX_SADDR = 3'd4,
        CH_TX_SIZE  = 3'd5,
        CH_TX_CFG   = 3'd6,
        CH_RSVD7    = 3'd7
    } ch_reg_e;

    // Global register offsets, relative to the global base G = NB_CH*8.
    localparam int unsigned G_STATUS   = 0;
    localparam int unsigned G_SETUP    = 1;
    localparam int unsigned G_ACK      = 2;
    localparam int unsigned G_IRQ_EN   = 3;
    localparam int unsigned G_NACK_CNT = 4;   // G+4+c holds NACK_CNT[c]

    // CFG register bit positions (write side: CLR/EN/CONT, read side: PEND/EN/CONT).
    localparam int unsigned CFG_CLR_BIT  = 5;
    localparam int unsigned CFG_EN_BIT   = 4;
    localparam int unsigned CFG_PEND_BIT = 5;
    localparam int unsigned CFG_CONT_BIT = 0;

    // Width of the optional per-core NACK event counter.
    localparam int unsigned NACK_CNT_W = 8;

    // Assemble the CFG read word: {26'0, pending, en, 3'0, continuous}.
    function automatic logic [31:0] cfg_rdata(input logic pend, input logic en, input logic cont);
        logic [31:0] v;
        v               = '0;
        v[CFG_PEND_BIT] = pend;
        v[CFG_EN_BIT]   = en;
        v[CFG_CONT_BIT] = cont;
        return v;
    endfunction

endpackage

// File: rtl/udma_i2c_reg_if_mc_if.sv
// udma_i2c_reg_if_mc_if: uDMA configuration bus (one access per cycle, always ready).
// The master drives address/data/strobe; the slave returns combinational read data.
interface udma_i2c_reg_if_mc_if #(
    parameter int CFG_AW = 5
);
    logic [31:0]       cfg_data_i;
    logic [CFG_AW-1:0] cfg_addr_i;
    logic              cfg_valid_i;
    logic              cfg_rwn_i;
    logic [31:0]       cfg_data_o;
    logic              cfg_ready_o;

    modport master (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  cfg_data_o, cfg_ready_o
    );

    modport slave (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output cfg_data_o, cfg_ready_o
    );
endinterface

// File: rtl/udma_i2c_reg_if_mc_ch.sv
// udma_i2c_reg_ch: one I2C core's RX and TX channel registers.
// Holds start address, size and continuous mode per direction, generates the
// one-cycle en/clr pulses and muxes the channel's read data from live channel status.
module udma_i2c_reg_ch
    import udma_i2c_reg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      i_wr,
    input  ch_reg_e                   i_k,
    input  logic [31:0]               i_wdata,
    input  logic                      i_rx_en,
    input  logic                      i_rx_pending,
    input  logic [L2_AWIDTH_NOAL-1:0] i_rx_curr_addr,
    input  logic [TRANS_SIZE-1:0]     i_rx_bytes_left,
    input  logic                      i_tx_en,
    input  logic                      i_tx_pending,
    input  logic [L2_AWIDTH_NOAL-1:0] i_tx_curr_addr,
    input  logic [TRANS_SIZE-1:0]     i_tx_bytes_left,
    output logic [L2_AWIDTH_NOAL-1:0] o_rx_startaddr,
    output logic [TRANS_SIZE-1:0]     o_rx_size,
    output logic                      o_rx_continuous,
    output logic                      o_rx_en,
    output logic                      o_rx_clr,
    output logic [L2_AWIDTH_NOAL-1:0] o_tx_startaddr,
    output logic [TRANS_SIZE-1:0]     o_tx_size,
    output logic                      o_tx_continuous,
    output logic                      o_tx_en,
    output logic                      o_tx_clr,
    output logic [31:0]               o_rdata
);

    logic [L2_AWIDTH_NOAL-1:0] r_rx_saddr, r_tx_saddr;
    logic [TRANS_SIZE-1:0]     r_rx_size,  r_tx_size;
    logic                      r_rx_cont,  r_tx_cont;
    logic                      r_rx_en,    r_tx_en;
    logic                      r_rx_clr,   r_tx_clr;
    logic                      w_unused_wdata;

    // Only the low bits of the write word land in registers; the rest is don't-care.
    assign w_unused_wdata = ^i_wdata;

    // Register writes; en/clr default low every cycle so a CFG write yields a single-cycle pulse.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_saddr <= '0;
            r_rx_size  <= '0;
            r_rx_cont  <= 1'b0;
            r_rx_en    <= 1'b0;
            r_rx_clr   <= 1'b0;
            r_tx_saddr <= '0;
            r_tx_size  <= '0;
            r_tx_cont  <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_clr   <= 1'b0;
        end else begin
            r_rx_en  <= 1'b0;
            r_rx_clr <= 1'b0;
            r_tx_en  <= 1'b0;
            r_tx_clr <= 1'b0;
            if (i_wr) begin
                case (i_k)
                    CH_RX_SADDR: r_rx_saddr <= i_wdata[L2_AWIDTH_NOAL-1:0];
                    CH_RX_SIZE:  r_rx_size  <= i_wdata[TRANS_SIZE-1:0];
                    CH_RX_CFG: begin
                        r_rx_cont <= i_wdata[CFG_CONT_BIT];
                        r_rx_en   <= i_wdata[CFG_EN_BIT];
                        r_rx_clr  <= i_wdata[CFG_CLR_BIT];
                    end
                    CH_TX_SADDR: r_tx_saddr <= i_wdata[L2_AWIDTH_NOAL-1:0];
                    CH_TX_SIZE:  r_tx_size  <= i_wdata[TRANS_SIZE-1:0];
                    CH_TX_CFG: begin
                        r_tx_cont <= i_wdata[CFG_CONT_BIT];
                        r_tx_en   <= i_wdata[CFG_EN_BIT];
                        r_tx_clr  <= i_wdata[CFG_CLR_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux: address/size words reflect the live channel position, not the programmed value.
    // NOTE: o_rdata gets a default first so no path through the case can infer a latch.
    always_comb begin
        o_rdata = '0;
        case (i_k)
            CH_RX_SADDR: o_rdata = 32'(i_rx_curr_addr);
            CH_RX_SIZE:  o_rdata = 32'(i_rx_bytes_left);
            CH_RX_CFG:   o_rdata = cfg_rdata(i_rx_pending, i_rx_en, r_rx_cont);
            CH_TX_SADDR: o_rdata = 32'(i_tx_curr_addr);
            CH_TX_SIZE:  o_rdata = 32'(i_tx_bytes_left);
            CH_TX_CFG:   o_rdata = cfg_rdata(i_tx_pending, i_tx_en, r_tx_cont);
            default:     o_rdata = '0;
        endcase
    end

    assign o_rx_startaddr  = r_rx_saddr;
    assign o_rx_size       = r_rx_size;
    assign o_rx_continuous = r_rx_cont;
    assign o_rx_en         = r_rx_en;
    assign o_rx_clr        = r_rx_clr;
    assign o_tx_startaddr  = r_tx_saddr;
    assign o_tx_size       = r_tx_size;
    assign o_tx_continuous = r_tx_cont;
    assign o_tx_en         = r_tx_en;
    assign o_tx_clr        = r_tx_clr;

endmodule

// File: rtl/udma_i2c_reg_if_mc.sv
// udma_i2c_reg_if_mc: cfg register file for NB_CH independent I2C cores.
// Decodes the cfg bus into NB_CH channel windows plus a global block (STATUS, SETUP,
// ACK, IRQ_EN, NACK_CNT), keeps sticky busy/arb-lost/NACK bits with clear-on-read,
// and drives a maskable level interrupt.
// Optional feature: define UDMA_I2C_NACK_CNT_EN to add saturating per-core NACK counters.
module udma_i2c_reg_if_mc
    import udma_i2c_reg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int NB_CH          = 2,
    parameter int CFG_AW         = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    udma_i2c_reg_if_mc_if.slave             cfg,
    output logic [NB_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [NB_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [NB_CH-1:0]                cfg_rx_continuous_o,
    output logic [NB_CH-1:0]                cfg_rx_en_o,
    output logic [NB_CH-1:0]                cfg_rx_clr_o,
    input  logic [NB_CH-1:0]                cfg_rx_en_i,
    input  logic [NB_CH-1:0]                cfg_rx_pending_i,
    input  logic [NB_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    output logic [NB_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [NB_CH*TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [NB_CH-1:0]                cfg_tx_continuous_o,
    output logic [NB_CH-1:0]                cfg_tx_en_o,
    output logic [NB_CH-1:0]                cfg_tx_clr_o,
    input  logic [NB_CH-1:0]                cfg_tx_en_i,
    input  logic [NB_CH-1:0]                cfg_tx_pending_i,
    input  logic [NB_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
    output logic [NB_CH-1:0]                cfg_do_rst_o,
    input  logic [NB_CH-1:0]                status_busy_i,
    input  logic [NB_CH-1:0]                status_al_i,
    input  logic [NB_CH-1:0]                nack_i,
    output logic                            irq_o
);

    localparam logic [CFG_AW-1:0] G_BASE = CFG_AW'(NB_CH * 8);

    logic                 w_wr, w_rd, w_is_glob;
    logic [CFG_AW-1:0]    w_goff;
    logic [CFG_AW-4:0]    w_ch_idx;
    ch_reg_e              w_ch_k;
    logic [NB_CH-1:0]     w_ch_sel;
    logic [31:0]          w_ch_rdata [NB_CH];
    logic [31:0]          w_rdata;
    logic                 w_clr_status, w_clr_ack;

    logic [NB_CH-1:0]     r_setup;
    logic [2*NB_CH-1:0]   r_irq_en;
    logic [NB_CH-1:0]     r_busy, r_al, r_nack;

    // Address decode: below G is a channel window (core = addr/8), at or above G the global block.
    assign w_wr      = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
    assign w_rd      = cfg.cfg_valid_i &  cfg.cfg_rwn_i;
    assign w_is_glob = (cfg.cfg_addr_i >= G_BASE);
    assign w_goff    = cfg.cfg_addr_i - G_BASE;
    assign w_ch_idx  = cfg.cfg_addr_i[CFG_AW-1:3];
    assign w_ch_k    = ch_reg_e'(cfg.cfg_addr_i[2:0]);

    assign w_clr_status = w_rd & w_is_glob & (w_goff == CFG_AW'(G_STATUS));
    assign w_clr_ack    = w_rd & w_is_glob & (w_goff == CFG_AW'(G_ACK));

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        assign w_ch_sel[c] = ~w_is_glob & (w_ch_idx == (CFG_AW-3)'(c));

        udma_i2c_reg_ch #(
            .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
            .TRANS_SIZE     (TRANS_SIZE)
        ) u_ch (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .i_wr            (w_wr & w_ch_sel[c]),
            .i_k             (w_ch_k),
            .i_wdata         (cfg.cfg_data_i),
            .i_rx_en         (cfg_rx_en_i[c]),
            .i_rx_pending    (cfg_rx_pending_i[c]),
            .i_rx_curr_addr  (cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .i_rx_bytes_left (cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
            .i_tx_en         (cfg_tx_en_i[c]),
            .i_tx_pending    (cfg_tx_pending_i[c]),
            .i_tx_curr_addr  (cfg_tx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .i_tx_bytes_left (cfg_tx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
            .o_rx_startaddr  (cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .o_rx_size       (cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
            .o_rx_continuous (cfg_rx_continuous_o[c]),
            .o_rx_en         (cfg_rx_en_o[c]),
            .o_rx_clr        (cfg_rx_clr_o[c]),
            .o_tx_startaddr  (cfg_tx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .o_tx_size       (cfg_tx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
            .o_tx_continuous (cfg_tx_continuous_o[c]),
            .o_tx_en         (cfg_tx_en_o[c]),
            .o_tx_clr        (cfg_tx_clr_o[c]),
            .o_rdata         (w_ch_rdata[c])
        );
    end

    // SETUP (per-core soft reset level) and IRQ_EN registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_setup  <= '0;
            r_irq_en <= '0;
        end else if (w_wr & w_is_glob) begin
            if (w_goff == CFG_AW'(G_SETUP))  r_setup  <= cfg.cfg_data_i[NB_CH-1:0];
            if (w_goff == CFG_AW'(G_IRQ_EN)) r_irq_en <= cfg.cfg_data_i[2*NB_CH-1:0];
        end
    end

    // Sticky status: an event in the same cycle as the clearing read keeps the bit set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
            r_al   <= '0;
            r_nack <= '0;
        end else begin
            r_busy <= (r_busy & ~{NB_CH{w_clr_status}}) | status_busy_i;
            r_al   <= (r_al   & ~{NB_CH{w_clr_status}}) | status_al_i;
            r_nack <= (r_nack & ~{NB_CH{w_clr_ack}})    | nack_i;
        end
    end

`ifdef UDMA_I2C_NACK_CNT_EN
    logic [NACK_CNT_W-1:0] r_nack_cnt [NB_CH];
    logic [NB_CH-1:0]      w_cnt_clr;

    for (genvar c = 0; c < NB_CH; c++) begin : g_cnt_clr
        assign w_cnt_clr[c] = w_rd & w_is_glob & (w_goff == CFG_AW'(G_NACK_CNT + c));
    end

    // Saturating NACK counters; a clearing read restarts the count from the current cycle's event.
    // NOTE: these are a small flop array, not RAM, so every entry is reset explicitly.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NB_CH; c++) begin
            if (rst_i) begin
                r_nack_cnt[c] <= '0;
            end else if (w_cnt_clr[c]) begin
                r_nack_cnt[c] <= NACK_CNT_W'(nack_i[c]);
            end else if (nack_i[c] && (r_nack_cnt[c] != '1)) begin
                r_nack_cnt[c] <= r_nack_cnt[c] + 1'b1;
            end
        end
    end
`else
    // Without the counter option there are no counter flops; G+4+c reads back 0.
`endif

    // Final read mux: channel windows first, then the global block; anything unmapped reads 0.
    always_comb begin
        w_rdata = '0;
        if (!w_is_glob) begin
            for (int c = 0; c < NB_CH; c++) begin
                if (w_ch_sel[c]) w_rdata = w_ch_rdata[c];
            end
        end else begin
            if (w_goff == CFG_AW'(G_STATUS)) w_rdata = 32'({r_al, r_busy});
            if (w_goff == CFG_AW'(G_SETUP))  w_rdata = 32'(r_setup);
            if (w_goff == CFG_AW'(G_ACK))    w_rdata = 32'(r_nack);
            if (w_goff == CFG_AW'(G_IRQ_EN)) w_rdata = 32'(r_irq_en);
`ifdef UDMA_I2C_NACK_CNT_EN
            for (int c = 0; c < NB_CH; c++) begin
                if (w_goff == CFG_AW'(G_NACK_CNT + c)) w_rdata = 32'(r_nack_cnt[c]);
            end
`endif
        end
    end

    assign cfg.cfg_data_o  = w_rdata;
    assign cfg.cfg_ready_o = 1'b1;
    assign cfg_do_rst_o    = r_setup;
    assign irq_o = (|(r_al & r_irq_en[NB_CH-1:0])) | (|(r_nack & r_irq_en[2*NB_CH-1:NB_CH]));

endmodule

// File: tb/tb_udma_i2c_reg_if_mc.sv
// tb_udma_i2c_reg_if_mc: directed, table-driven bench for udma_i2c_reg_if_mc (NB_CH=2, CFG_AW=5).
// Register map used here: ch0 words 0..7, ch1 words 8..15, STATUS 16, SETUP 17, ACK 18,
// IRQ_EN 19, NACK_CNT 20/21. Build with UDMA_I2C_NACK_CNT_EN to exercise the counters.
module tb_udma_i2c_reg_if_mc;

    localparam int L2W = 12;
    localparam int TSW = 16;
    localparam int NCH = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    udma_i2c_reg_if_mc_if #(.CFG_AW(AW)) cfg_bus ();

    logic [NCH*L2W-1:0] rx_startaddr, tx_startaddr;
    logic [NCH*TSW-1:0] rx_size, tx_size;
    logic [NCH-1:0]     rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr, do_rst;
    logic [NCH-1:0]     rx_en_i, rx_pend_i, tx_en_i, tx_pend_i;
    logic [NCH*L2W-1:0] rx_curr_i, tx_curr_i;
    logic [NCH*TSW-1:0] rx_bl_i, tx_bl_i;
    logic [NCH-1:0]     busy_i, al_i, nack_i;
    logic               irq;

    udma_i2c_reg_if_mc #(
        .L2_AWIDTH_NOAL (L2W),
        .TRANS_SIZE     (TSW),
        .NB_CH          (NCH),
        .CFG_AW         (AW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cfg                 (cfg_bus),
        .cfg_rx_startaddr_o  (rx_startaddr),
        .cfg_rx_size_o       (rx_size),
        .cfg_rx_continuous_o (rx_cont),
        .cfg_rx_en_o         (rx_en),
        .cfg_rx_clr_o        (rx_clr),
        .cfg_rx_en_i         (rx_en_i),
        .cfg_rx_pending_i    (rx_pend_i),
        .cfg_rx_curr_addr_i  (rx_curr_i),
        .cfg_rx_bytes_left_i (rx_bl_i),
        .cfg_tx_startaddr_o  (tx_startaddr),
        .cfg_tx_size_o       (tx_size),
        .cfg_tx_continuous_o (tx_cont),
        .cfg_tx_en_o         (tx_en),
        .cfg_tx_clr_o        (tx_clr),
        .cfg_tx_en_i         (tx_en_i),
        .cfg_tx_pending_i    (tx_pend_i),
        .cfg_tx_curr_addr_i  (tx_curr_i),
        .cfg_tx_bytes_left_i (tx_bl_i),
        .cfg_do_rst_o        (do_rst),
        .status_busy_i       (busy_i),
        .status_al_i         (al_i),
        .nack_i              (nack_i),
        .irq_o               (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One cfg access: drive at negedge, sample read data 1 ns later, return 1 ns after the edge.
    task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        @(negedge clk);
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_rwn_i   = ~wr;
        cfg_bus.cfg_addr_i  = addr;
        cfg_bus.cfg_data_i  = wdata;
        #1 rdata = cfg_bus.cfg_data_o;
        @(posedge clk);
        #1;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i   = 1'b1;
    endtask

    typedef enum int {OBS_RD, OBS_CONT, OBS_TX_SADDR0, OBS_TX_SIZE0, OBS_DO_RST} obs_e;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        obs_e          obs;
        logic [31:0]   exp;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic logic [31:0] observe(input obs_e o, input logic [31:0] rd);
        case (o)
            OBS_CONT:      return 32'({tx_cont, rx_cont});
            OBS_TX_SADDR0: return 32'(tx_startaddr[L2W-1:0]);
            OBS_TX_SIZE0:  return 32'(tx_size[TSW-1:0]);
            OBS_DO_RST:    return 32'(do_rst);
            default:       return rd;
        endcase
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        // Live channel status seen by the read mux (core 0 in the low slice).
        rx_curr_i = {12'hABC, 12'h0DE};
        rx_bl_i   = {16'h1111, 16'h2222};
        tx_curr_i = {12'h456, 12'h789};
        tx_bl_i   = {16'h3333, 16'h4444};
        rx_en_i   = 2'b10;
        rx_pend_i = 2'b01;
        tx_en_i   = 2'b01;
        tx_pend_i = 2'b11;
        busy_i    = '0;
        al_i      = '0;
        nack_i    = '0;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i   = 1'b1;
        cfg_bus.cfg_addr_i  = '0;
        cfg_bus.cfg_data_i  = '0;

        vecs[0]  = '{1'b0, 5'd0,  32'h0,         OBS_RD,        32'h0DE};
        vecs[1]  = '{1'b0, 5'd8,  32'h0,         OBS_RD,        32'hABC};
        vecs[2]  = '{1'b0, 5'd5,  32'h0,         OBS_RD,        32'h4444};
        vecs[3]  = '{1'b0, 5'd13, 32'h0,         OBS_RD,        32'h3333};
        vecs[4]  = '{1'b0, 5'd2,  32'h0,         OBS_RD,        32'h20};
        vecs[5]  = '{1'b1, 5'd2,  32'h01,        OBS_CONT,      32'h1};
        vecs[6]  = '{1'b0, 5'd2,  32'h0,         OBS_RD,        32'h21};
        vecs[7]  = '{1'b0, 5'd10, 32'h0,         OBS_RD,        32'h10};
        vecs[8]  = '{1'b0, 5'd14, 32'h0,         OBS_RD,        32'h20};
        vecs[9]  = '{1'b0, 5'd6,  32'h0,         OBS_RD,        32'h30};
        vecs[10] = '{1'b1, 5'd4,  32'hFFFF_F5A5, OBS_TX_SADDR0, 32'h5A5};
        vecs[11] = '{1'b1, 5'd5,  32'hABCD_1234, OBS_TX_SIZE0,  32'h1234};
        vecs[12] = '{1'b1, 5'd3,  32'hFFFF_FFFF, OBS_CONT,      32'h1};
        vecs[13] = '{1'b0, 5'd3,  32'h0,         OBS_RD,        32'h0};
        vecs[14] = '{1'b0, 5'd7,  32'h0,         OBS_RD,        32'h0};
        vecs[15] = '{1'b1, 5'd17, 32'h2,         OBS_DO_RST,    32'h2};
        vecs[16] = '{1'b0, 5'd22, 32'h0,         OBS_RD,        32'h0};
        vecs[17] = '{1'b0, 5'd20, 32'h0,         OBS_RD,        32'h0};
        vecs[18] = '{1'b1, 5'd22, 32'hFFFF_FFFF, OBS_DO_RST,    32'h2};
        vecs[19] = '{1'b0, 5'd16, 32'h0,         OBS_RD,        32'h0};
        vecs[20] = '{1'b0, 5'd18, 32'h0,         OBS_RD,        32'h0};
        vecs[21] = '{1'b1, 5'd17, 32'h0,         OBS_DO_RST,    32'h0};
        vecs[22] = '{1'b0, 5'd12, 32'h0,         OBS_RD,        32'h456};
        vecs[23] = '{1'b0, 5'd1,  32'h0,         OBS_RD,        32'h2222};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_startaddr", 32'({rx_startaddr, tx_startaddr}), 32'h0);
        check("rst_size", rx_size | tx_size, 32'h0);
        check("rst_ctrl", 32'({rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr, do_rst, irq}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready", 32'(cfg_bus.cfg_ready_o), 32'h1);

        // Table-driven single accesses.
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d", i), observe(vecs[i].obs, rd), vecs[i].exp);
        end

        // Channel 1 RX programming with en/clr pulses.
        access(1'b1, 5'd8, 32'h123, rd);
        check("t1_saddr1", 32'(rx_startaddr[2*L2W-1:L2W]), 32'h123);
        access(1'b1, 5'd9, 32'h40, rd);
        check("t1_size1", 32'(rx_size[2*TSW-1:TSW]), 32'h40);
        check("t1_en_before", 32'({rx_en, rx_clr}), 32'h0);
        access(1'b1, 5'd10, 32'h31, rd);
        check("t1_cont", 32'(rx_cont), 32'h3);
        check("t1_pulse_hi", 32'({rx_en, rx_clr, tx_en, tx_clr}), 32'b10_10_00_00);
        @(posedge clk);
        #1 check("t1_pulse_lo", 32'({rx_en, rx_clr}), 32'h0);
        check("t1_ch0_kept", 32'({rx_startaddr[L2W-1:0], rx_size[TSW-1:0]}), 32'h0);

        // Arb-lost and busy sticky bits, clear on STATUS read.
        @(negedge clk) al_i = 2'b01;
        @(negedge clk) al_i = 2'b00;
        access(1'b0, 5'd16, 32'h0, rd);
        check("t2_status_al", rd, 32'h4);
        access(1'b0, 5'd16, 32'h0, rd);
        check("t2_status_clr", rd, 32'h0);
        @(negedge clk) busy_i = 2'b10;
        @(negedge clk) busy_i = 2'b00;
        access(1'b0, 5'd16, 32'h0, rd);
        check("t2_status_busy", rd, 32'h2);

        // NACK held during the ACK read: set wins over clear.
        @(negedge clk) nack_i = 2'b10;
        access(1'b0, 5'd18, 32'h0, rd);
        check("t3_ack_first", rd, 32'h2);
        nack_i = 2'b00;
        access(1'b0, 5'd18, 32'h0, rd);
        check("t3_ack_kept", rd, 32'h2);
        access(1'b0, 5'd18, 32'h0, rd);
        check("t3_ack_clr", rd, 32'h0);

        // Interrupt from NACK core 1, then masked/unmasked arb-lost.
        access(1'b1, 5'd19, 32'h8, rd);
        check("t4_irq_idle", 32'(irq), 32'h0);
        @(negedge clk) nack_i = 2'b10;
        #1 check("t4_irq_not_comb", 32'(irq), 32'h0);
        @(posedge clk);
        #1 check("t4_irq_set", 32'(irq), 32'h1);
        @(negedge clk) nack_i = 2'b00;
        access(1'b0, 5'd18, 32'h0, rd);
        check("t4_ack_rd", rd, 32'h2);
        check("t4_irq_clr", 32'(irq), 32'h0);
        @(negedge clk) al_i = 2'b01;
        @(negedge clk) al_i = 2'b00;
        check("t4_al_masked", 32'(irq), 32'h0);
        access(1'b1, 5'd19, 32'h1, rd);
        check("t4_al_unmasked", 32'(irq), 32'h1);
        access(1'b0, 5'd16, 32'h0, rd);
        check("t4_al_status", rd, 32'h4);
        check("t4_al_irq_clr", 32'(irq), 32'h0);

        // NACK counter on core 0: saturation, clear, and increment coincident with clear.
        @(negedge clk) nack_i = 2'b01;
        repeat (300) @(negedge clk);
        nack_i = 2'b00;
        access(1'b0, 5'd20, 32'h0, rd);
`ifdef UDMA_I2C_NACK_CNT_EN
        check("t5_cnt_sat", rd, 32'd255);
`else
        check("t5_cnt_absent", rd, 32'd0);
`endif
        access(1'b0, 5'd20, 32'h0, rd);
        check("t5_cnt_clr", rd, 32'd0);
        @(negedge clk) nack_i = 2'b01;
        access(1'b0, 5'd20, 32'h0, rd);
        nack_i = 2'b00;
`ifdef UDMA_I2C_NACK_CNT_EN
        check("t5_cnt_one", rd, 32'd1);
        access(1'b0, 5'd20, 32'h0, rd);
        check("t5_cnt_restart", rd, 32'd1);
`else
        check("t5_cnt_one_absent", rd, 32'd0);
`endif
        access(1'b0, 5'd21, 32'h0, rd);
        check("t5_cnt1_idle", rd, 32'd0);
        access(1'b0, 5'd18, 32'h0, rd);
        check("t5_ack0", rd, 32'h1);

        // Mid-operation reset wins over a concurrent write and event.
        access(1'b1, 5'd17, 32'h3, rd);
        check("t6_do_rst", 32'(do_rst), 32'h3);
        access(1'b1, 5'd19, 32'h1, rd);
        @(negedge clk) al_i = 2'b01;
        @(negedge clk) al_i = 2'b00;
        check("t6_irq_pre", 32'(irq), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        al_i = 2'b01;
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_rwn_i   = 1'b0;
        cfg_bus.cfg_addr_i  = 5'd0;
        cfg_bus.cfg_data_i  = 32'hFFF;
        @(posedge clk);
        #1;
        check("t6_ctrl", 32'({rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr, do_rst, irq}), 32'h0);
        check("t6_regs", 32'({rx_startaddr, tx_startaddr}) | 32'(rx_size) | 32'(tx_size), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        al_i = 2'b00;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i   = 1'b1;
        access(1'b0, 5'd16, 32'h0, rd);
        check("t6_status", rd, 32'h0);
        check("t6_saddr0", 32'(rx_startaddr[L2W-1:0]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
